// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU and load-unit results into one register-bank write port
// with a round-robin pointer, one-cycle registered write and read-port bypass flags.
module wb_arbiter #(
    parameter int PRIO_LSU = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        STALL,
    input  logic        ALU_VALID,
    input  logic [4:0]  ALU_DIR,
    input  logic [31:0] ALU_DATA,
    output logic        ALU_READY,
    input  logic        LSU_VALID,
    input  logic [4:0]  LSU_DIR,
    input  logic [31:0] LSU_DATA,
    output logic        LSU_READY,
    output logic [4:0]  DIR_WR,
    output logic [31:0] DI,
    output logic        REG_WR,
    input  logic [4:0]  DIR_A,
    input  logic [4:0]  DIR_B,
    output logic        BYP_A,
    output logic        BYP_B,
    output logic [31:0] WB_CNT,
    output logic        fsm_state
);

    // Handshake: a source transfers on a rising edge where its VALID and READY are both
    // high; it holds VALID/DIR/DATA stable until then. READY is purely combinational.

    typedef enum logic {
        FAV_ALU = 1'b0,
        FAV_LSU = 1'b1
    } ptr_t;

    localparam ptr_t RESET_PTR = (PRIO_LSU != 0) ? FAV_LSU : FAV_ALU;

    ptr_t        state_q;
    ptr_t        state_d;
    logic        alu_take;
    logic        lsu_take;
    logic        xfer;
    logic [4:0]  win_dir;
    logic [31:0] win_data;

    // Pointer state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RESET_PTR;
        end else begin
            state_q <= state_d;
        end
    end

    // After a transfer the pointer favours whichever source did not win
    always_comb begin
        state_d = state_q;
        if (alu_take) begin
            state_d = FAV_LSU;
        end else if (lsu_take) begin
            state_d = FAV_ALU;
        end
    end

    // Grant outputs; reset and STALL both close the port regardless of VALID
    always_comb begin
        alu_take = 1'b0;
        lsu_take = 1'b0;
        if (rst_n && !STALL) begin
            if (ALU_VALID && LSU_VALID) begin
                if (state_q == FAV_LSU) begin
                    lsu_take = 1'b1;
                end else begin
                    alu_take = 1'b1;
                end
            end else begin
                alu_take = ALU_VALID;
                lsu_take = LSU_VALID;
            end
        end
    end

    assign ALU_READY = alu_take;
    assign LSU_READY = lsu_take;
    assign xfer      = alu_take | lsu_take;
    assign fsm_state = state_q;

    always_comb begin
        win_dir  = ALU_DIR;
        win_data = ALU_DATA;
        if (lsu_take) begin
            win_dir  = LSU_DIR;
            win_data = LSU_DATA;
        end
    end

    // x0 writes still move address/data but never raise the write enable or the counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            DIR_WR <= 5'd0;
            DI     <= 32'd0;
            REG_WR <= 1'b0;
            WB_CNT <= 32'd0;
        end else if (xfer) begin
            DIR_WR <= win_dir;
            DI     <= win_data;
            REG_WR <= (win_dir != 5'd0);
            if ((win_dir != 5'd0) && (WB_CNT != 32'hFFFF_FFFF)) begin
                WB_CNT <= WB_CNT + 32'd1;
            end
        end else begin
            REG_WR <= 1'b0;
        end
    end

    assign BYP_A = REG_WR & (DIR_WR == DIR_A);
    assign BYP_B = REG_WR & (DIR_WR == DIR_B);

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a
// rule-level arbitration model with an expected-write queue.
module tb_wb_arbiter;

    localparam int PRIO = 1;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        alu_valid;
    logic [4:0]  alu_dir;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_dir;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic [4:0]  dir_wr;
    logic [31:0] di;
    logic        reg_wr;
    logic [4:0]  dir_a;
    logic [4:0]  dir_b;
    logic        byp_a;
    logic        byp_b;
    logic [31:0] wb_cnt;
    logic        fsm_state;

    int checks;
    int failures;

    // model state
    logic        m_fav_lsu;
    logic        m_reg_wr;
    logic [4:0]  m_dir_wr;
    logic [31:0] m_di;
    logic [31:0] m_cnt;
    int          m_last;
    logic [36:0] exp_q[$];

    wb_arbiter #(.PRIO_LSU(PRIO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .STALL     (stall),
        .ALU_VALID (alu_valid),
        .ALU_DIR   (alu_dir),
        .ALU_DATA  (alu_data),
        .ALU_READY (alu_ready),
        .LSU_VALID (lsu_valid),
        .LSU_DIR   (lsu_dir),
        .LSU_DATA  (lsu_data),
        .LSU_READY (lsu_ready),
        .DIR_WR    (dir_wr),
        .DI        (di),
        .REG_WR    (reg_wr),
        .DIR_A     (dir_a),
        .DIR_B     (dir_b),
        .BYP_A     (byp_a),
        .BYP_B     (byp_b),
        .WB_CNT    (wb_cnt),
        .fsm_state (fsm_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // 0 = nobody, 1 = ALU, 2 = LSU
    function automatic int model_winner();
        if (!rst_n || stall) return 0;
        if (alu_valid && lsu_valid) return m_fav_lsu ? 2 : 1;
        if (alu_valid) return 1;
        if (lsu_valid) return 2;
        return 0;
    endfunction

    // One clock: predicts the edge, lets it happen, then updates the model and
    // withdraws the winning request the way a requester would.
    task automatic cycle();
        int          w;
        logic        r;
        logic [4:0]  d;
        logic [31:0] v;
        w = model_winner();
        r = rst_n;
        d = (w == 2) ? lsu_dir : alu_dir;
        v = (w == 2) ? lsu_data : alu_data;
        @(posedge clk);
        #1;
        m_last = w;
        if (!r) begin
            m_reg_wr  = 1'b0;
            m_dir_wr  = 5'd0;
            m_di      = 32'd0;
            m_cnt     = 32'd0;
            m_fav_lsu = (PRIO != 0);
            exp_q.delete();
        end else if (w != 0) begin
            m_dir_wr = d;
            m_di     = v;
            m_reg_wr = (d != 5'd0);
            if (m_reg_wr && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_fav_lsu = (w == 1);
            exp_q.push_back({d, v});
            if (w == 1) alu_valid = 1'b0;
            else lsu_valid = 1'b0;
        end else begin
            m_reg_wr = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_dir = 5'd3; alu_data = 32'h33;
        lsu_valid = 1'b1; lsu_dir = 5'd4; lsu_data = 32'h44;
        #1;
        checks++;
        if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: alu=%b lsu=%b required 0 0", alu_ready, lsu_ready);
        end
        cycle();
        cycle();
        checks++;
        if (reg_wr !== 1'b0 || dir_wr !== 5'd0 || di !== 32'd0 || wb_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs: reg_wr=%b dir_wr=%0d di=%h cnt=%0d required 0 0 0 0",
                     reg_wr, dir_wr, di, wb_cnt);
        end
        checks++;
        if (fsm_state !== 1'b1) begin
            failures++;
            $display("FAIL reset_ptr: got %b required 1 (FAV_LSU)", fsm_state);
        end
        checks++;
        if (byp_a !== 1'b0 || byp_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_byp: a=%b b=%b required 0 0", byp_a, byp_b);
        end
        rst_n = 1'b1;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        cycle();
        checks++;
        if (reg_wr !== 1'b0 || byp_a !== 1'b0 || byp_b !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: reg_wr=%b byp_a=%b byp_b=%b required 0 0 0", reg_wr, byp_a, byp_b);
        end
    endtask

    task automatic test_priority();
        alu_valid = 1'b1; alu_dir = 5'd5; alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_dir = 5'd6; lsu_data = 32'h22;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            failures++;
            $display("FAIL prio_grant: lsu=%b alu=%b required 1 0", lsu_ready, alu_ready);
        end
        cycle();
        checks++;
        if (reg_wr !== 1'b1 || dir_wr !== 5'd6 || di !== 32'h22 || alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL prio_first: reg_wr=%b dir_wr=%0d di=%h alu_ready=%b required 1 6 22 1",
                     reg_wr, dir_wr, di, alu_ready);
        end
        cycle();
        checks++;
        if (reg_wr !== 1'b1 || dir_wr !== 5'd5 || di !== 32'h11) begin
            failures++;
            $display("FAIL prio_second: reg_wr=%b dir_wr=%0d di=%h required 1 5 11", reg_wr, dir_wr, di);
        end
    endtask

    task automatic test_x0();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_dir = 5'd0; alu_data = 32'hDEAD;
            #1;
            checks++;
            if (alu_ready !== 1'b1) begin
                failures++;
                $display("FAIL x0_ready: got %b required 1", alu_ready);
            end
            cycle();
            checks++;
            if (reg_wr !== 1'b0 || dir_wr !== 5'd0 || di !== 32'hDEAD || wb_cnt !== cnt0) begin
                failures++;
                $display("FAIL x0_write: reg_wr=%b dir_wr=%0d di=%h cnt=%0d required 0 0 dead %0d",
                         reg_wr, dir_wr, di, wb_cnt, cnt0);
            end
        end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            alu_valid = 1'b1; alu_dir = 5'(i); alu_data = 32'(i);
            cycle();
            checks++;
            if (reg_wr !== 1'b1 || dir_wr !== 5'(i) || di !== 32'(i)) begin
                failures++;
                $display("FAIL b2b_write%0d: reg_wr=%b dir_wr=%0d di=%0d required 1 %0d %0d",
                         i, reg_wr, dir_wr, di, i, i);
            end
        end
        checks++;
        if (wb_cnt !== 32'd4) begin
            failures++;
            $display("FAIL b2b_count: got %0d required 4", wb_cnt);
        end
        cycle();
        checks++;
        if (reg_wr !== 1'b0 || dir_wr !== 5'd4 || di !== 32'd4) begin
            failures++;
            $display("FAIL idle_hold: reg_wr=%b dir_wr=%0d di=%0d required 0 4 4", reg_wr, dir_wr, di);
        end
    endtask

    task automatic test_bypass();
        alu_valid = 1'b1; alu_dir = 5'd7; alu_data = 32'h7777;
        cycle();
        dir_a = 5'd7; dir_b = 5'd8;
        #1;
        checks++;
        if (byp_a !== 1'b1 || byp_b !== 1'b0) begin
            failures++;
            $display("FAIL bypass_ab: a=%b b=%b required 1 0", byp_a, byp_b);
        end
        dir_a = 5'd9; dir_b = 5'd7;
        #1;
        checks++;
        if (byp_a !== 1'b0 || byp_b !== 1'b1) begin
            failures++;
            $display("FAIL bypass_ba: a=%b b=%b required 0 1", byp_a, byp_b);
        end
        cycle();
        checks++;
        if (byp_b !== 1'b0) begin
            failures++;
            $display("FAIL bypass_idle: b=%b required 0", byp_b);
        end
    endtask

    task automatic test_stall();
        logic fav;
        fav = m_fav_lsu;
        stall = 1'b1;
        alu_valid = 1'b1; alu_dir = 5'd9;  alu_data = 32'h99;
        lsu_valid = 1'b1; lsu_dir = 5'd10; lsu_data = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready: alu=%b lsu=%b required 0 0", alu_ready, lsu_ready);
            end
            cycle();
            checks++;
            if (reg_wr !== 1'b0 || fsm_state !== fav) begin
                failures++;
                $display("FAIL stall_hold: reg_wr=%b ptr=%b required 0 %b", reg_wr, fsm_state, fav);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (lsu_ready !== fav || alu_ready !== !fav) begin
            failures++;
            $display("FAIL stall_release: lsu=%b alu=%b required %b %b", lsu_ready, alu_ready, fav, !fav);
        end
        cycle();
        checks++;
        if (reg_wr !== 1'b1 || dir_wr !== (fav ? 5'd10 : 5'd9)) begin
            failures++;
            $display("FAIL stall_first: reg_wr=%b dir_wr=%0d required 1 %0d", reg_wr, dir_wr, fav ? 10 : 9);
        end
        cycle();
        checks++;
        if (reg_wr !== 1'b1 || dir_wr !== (fav ? 5'd9 : 5'd10)) begin
            failures++;
            $display("FAIL stall_second: reg_wr=%b dir_wr=%0d required 1 %0d", reg_wr, dir_wr, fav ? 9 : 10);
        end
    endtask

    task automatic test_random();
        logic [36:0] e;
        int          w;
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            if (!alu_valid && $urandom_range(0, 2) != 0) begin
                alu_valid = 1'b1;
                alu_dir   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                alu_data  = $urandom;
            end
            if (!lsu_valid && $urandom_range(0, 2) != 0) begin
                lsu_valid = 1'b1;
                lsu_dir   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                lsu_data  = $urandom;
            end
            stall = ($urandom_range(0, 3) == 0);
            #1;
            w = model_winner();
            checks++;
            if (alu_ready !== (w == 1) || lsu_ready !== (w == 2)) begin
                failures++;
                $display("FAIL rand_ready[%0d]: alu=%b lsu=%b required %b %b",
                         n, alu_ready, lsu_ready, (w == 1), (w == 2));
            end
            cycle();
            checks++;
            if (reg_wr !== m_reg_wr || wb_cnt !== m_cnt || fsm_state !== m_fav_lsu) begin
                failures++;
                $display("FAIL rand_state[%0d]: reg_wr=%b cnt=%0d ptr=%b required %b %0d %b",
                         n, reg_wr, wb_cnt, fsm_state, m_reg_wr, m_cnt, m_fav_lsu);
            end
            if (m_last != 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_queue[%0d]: expected write missing", n);
                end else begin
                    e = exp_q.pop_front();
                    if ({dir_wr, di} !== e) begin
                        failures++;
                        $display("FAIL rand_write[%0d]: dir_wr=%0d di=%h required %0d %h",
                                 n, dir_wr, di, e[36:32], e[31:0]);
                    end
                end
            end
            dir_a = 5'($urandom_range(0, 31));
            dir_b = ($urandom_range(0, 1) == 0) ? m_dir_wr : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (byp_a !== (m_reg_wr && m_dir_wr == dir_a) || byp_b !== (m_reg_wr && m_dir_wr == dir_b)) begin
                failures++;
                $display("FAIL rand_byp[%0d]: a=%b b=%b required %b %b", n, byp_a, byp_b,
                         (m_reg_wr && m_dir_wr == dir_a), (m_reg_wr && m_dir_wr == dir_b));
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_reset_midstream();
        alu_valid = 1'b1; alu_dir = 5'd12; alu_data = 32'hC0C0;
        lsu_valid = 1'b1; lsu_dir = 5'd13; lsu_data = 32'hD0D0;
        cycle();
        cycle();
        rst_n = 1'b0;
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        #1;
        checks++;
        if (reg_wr !== 1'b1 || alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_pending: reg_wr=%b alu=%b lsu=%b required 1 0 0", reg_wr, alu_ready, lsu_ready);
        end
        cycle();
        checks++;
        if (reg_wr !== 1'b0 || wb_cnt !== 32'd0 || fsm_state !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: reg_wr=%b cnt=%0d ptr=%b required 0 0 1", reg_wr, wb_cnt, fsm_state);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_grant: lsu=%b alu=%b required 1 0", lsu_ready, alu_ready);
        end
        cycle();
        checks++;
        if (reg_wr !== 1'b1 || dir_wr !== 5'd13 || di !== 32'hD0D0 || wb_cnt !== 32'd1) begin
            failures++;
            $display("FAIL midreset_write: reg_wr=%b dir_wr=%0d di=%h cnt=%0d required 1 13 d0d0 1",
                     reg_wr, dir_wr, di, wb_cnt);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        alu_valid = 1'b0; alu_dir = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_dir = 5'd0; lsu_data = 32'd0;
        dir_a     = 5'd0; dir_b = 5'd0;
        m_fav_lsu = (PRIO != 0);
        m_reg_wr  = 1'b0; m_dir_wr = 5'd0; m_di = 32'd0; m_cnt = 32'd0; m_last = 0;
        test_reset();
        test_priority();
        test_x0();
        test_back_to_back();
        test_bypass();
        test_stall();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter: PRIO_LSU, default 1, sets the round-robin pointer after reset (1 = LSU favoured first, 0 = ALU favoured first).
REQ-002 clk  input  1  rising-edge clock, same domain as the register bank.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 STALL  input  1  when high, no write-back is accepted.
REQ-005 ALU_VALID  input  1  ALU write-back request.
REQ-006 ALU_DIR  input  5  ALU destination register (rd).
REQ-007 ALU_DATA  input  32  ALU result.
REQ-008 ALU_READY  output  1  ALU request accepted this cycle.
REQ-009 LSU_VALID  input  1  load-unit write-back request.
REQ-010 LSU_DIR  input  5  load destination register.
REQ-011 LSU_DATA  input  32  load data.
REQ-012 LSU_READY  output  1  LSU request accepted this cycle.
REQ-013 DIR_WR  output  5  registered write address to the register bank.
REQ-014 DI  output  32  registered write data to the register bank.
REQ-015 REG_WR  output  1  registered write enable to the register bank.
REQ-016 DIR_A, DIR_B  input  5 each  current read addresses (rs1, rs2).
REQ-017 BYP_A, BYP_B  output  1 each  forward DI onto read port A/B this cycle.
REQ-018 WB_CNT  output  32  count of committed (non-x0) writes.

Function
REQ-019 Transfer occurs on a rising edge where VALID and READY are both high; VALID/DIR/DATA are held by the requester until transfer.
REQ-020 READY is combinational: high only for the granted requester; both low when STALL=1 or the requester's VALID=0.
REQ-021 Single valid requester (STALL=0): that requester is granted.
REQ-022 Both valid (STALL=0): the requester named by the pointer is granted; the other is held off.
REQ-023 Pointer FSM has two states, FAV_ALU and FAV_LSU; after every transfer it moves to favour the non-granted source; it does not change without a transfer.
REQ-024 Latency: one cycle. On a transfer at edge N, DIR_WR/DI take the winner's DIR/DATA after edge N, and REG_WR=1 after edge N if DIR!=0.
REQ-025 Writes to x0 (DIR=0) are accepted (READY high, pointer advances) but give REG_WR=0 after the edge; DIR_WR/DI still update; WB_CNT does not change.
REQ-026 No transfer at edge N: REG_WR=0 after edge N; DIR_WR/DI hold their values.
REQ-027 Sustained throughput: one write per cycle; two requesters alternate with no idle cycle.
REQ-028 BYP_A = REG_WR & (DIR_WR==DIR_A); BYP_B is the same with DIR_B; both are combinational.
REQ-029 WB_CNT increments by 1 on each edge where REG_WR is set to 1, and saturates at 0xFFFFFFFF.
REQ-030 STALL takes priority over VALID; a request pending during STALL keeps its pointer position.

Reset
REQ-031 When rst_n=0 at a rising edge:
- REG_WR=0, DIR_WR=0, DI=0, WB_CNT=0.
- Pointer = FAV_LSU if PRIO_LSU=1, else FAV_ALU.
REQ-032 While rst_n=0, ALU_READY=0 and LSU_READY=0.
REQ-033 A transfer accepted at the edge before reset is asserted still appears on REG_WR for one cycle. A request pending when reset is asserted is not accepted until the first edge after rst_n returns high.
REQ-034 BYP_A/BYP_B are 0 during reset and immediately after it, because REG_WR=0.

Verification
REQ-035 After reset (PRIO_LSU=1), both valid, ALU x5=0x11, LSU x6=0x22 -> cycle 1: LSU_READY=1; next cycle REG_WR=1, DIR_WR=6, DI=0x22, ALU_READY=1; following cycle DIR_WR=5, DI=0x11.
REQ-036 ALU_VALID held high with ALU_DIR=0, DATA=0xDEAD -> ALU_READY=1, REG_WR=0, WB_CNT unchanged.
REQ-037 Back-to-back ALU writes x1..x4 (data 1..4), LSU idle -> REG_WR high 4 consecutive cycles, WB_CNT=4.
REQ-038 REG_WR=1 with DIR_WR=7, DIR_A=7, DIR_B=8 -> BYP_A=1, BYP_B=0.
REQ-039 STALL=1 for 3 cycles with both valid -> both READY=0, REG_WR=0, pointer unchanged; STALL=0 -> favoured source granted first.
REQ-040 rst_n=0 for one edge during alternating traffic -> next cycle REG_WR=0, WB_CNT=0, pointer=FAV_LSU; the first grant after release goes to LSU.
